irq_timer_dev: RTL and testbench
================================

// Module: irq_timer_dev
// PURPOSE
//  Memory-mapped countdown timer with an interrupt-acknowledge register, on the CPU data bus behind the bridge.
//  Drives the CPU interrupt line. The CPU clears a pending request by storing to BASE+0x20, the same handshake the
//  system bench uses for its external interrupt at 0x7f20. Owns its registers; responds to word/byte stores and loads.
// PARAMETERS
//  BASE        32'h0000_7f00  byte base of the 64-byte register window; BASE[5:0] must be 0
//  ACK_OFF     6'h20          window offset of the write-only acknowledge register
// PORTS
//  clk         in   1   clock; all state updates on the rising edge
//  reset       in   1   synchronous, active-high reset
//  addr        in   32  byte address from the bridge; bits [1:0] are ignored
//  byteen      in   4   byte write enables; 4'b0000 means no write
//  wdata       in   32  store data, already lane-aligned
//  rdata       out  32  load data, combinational from addr
//  irq         out  1   interrupt request = pending & CTRL.IM
// BEHAVIOUR
//  Select: sel = (addr[31:6] == BASE[31:6]). Writes with sel=0 or byteen=0 are ignored.
//  Registers, all byte-writable per byteen lane:
//   0x00 CTRL: [3] IM, [2:1] MODE, [0] EN. Bits [31:4] read 0 and ignore writes.
//   0x04 PRESET: read/write.
//   0x08 COUNT: read-only; writes are ignored.
//   ACK_OFF: write-only. Any byteen!=0 clears pending. Reads return 0.
//   All other offsets read 0 and ignore writes.
//  Reset values: CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE, irq=0.
//  State machine (2-bit state). It uses register values from before this cycle's bus write.
//   IDLE: COUNT holds. If EN=1, go to LOAD.
//   LOAD: COUNT<=PRESET, go to CNT.
//   CNT:  If EN=0, go to IDLE with COUNT frozen.
//         Else if COUNT>1, COUNT<=COUNT-1.
//         Else (COUNT is 1 or 0), COUNT<=0 and go to INT.
//   INT:  pending<=1.
//         MODE=00 (one-shot): EN<=0, go to IDLE.
//         MODE=01 (auto-reload): go to LOAD.
//         MODE=1x: behaves as 00.
//  Latency: with EN first seen in IDLE at cycle t and PRESET=N>=1, the state is INT at t+N+2, and pending reads 1
//   from t+N+3. PRESET=0 behaves as PRESET=1.
//  Collisions:
//   - A bus write to CTRL overrides the INT-state EN clear in the same cycle (the bus wins).
//   - pending set in INT plus an ACK write in the same cycle: pending ends at 1 (the set wins).
//   - Writing PRESET while counting does not affect COUNT until the next LOAD.
//   - Clearing EN mid-count freezes COUNT. Setting EN again goes IDLE->LOAD, i.e. a fresh count from PRESET.
//  Clearing IM masks irq but keeps pending. Setting IM again re-asserts irq if pending=1.
//  irq is combinational from registered pending and IM (no extra delay). rdata has no side effects.
//  Reset asserted mid-count returns everything to reset values on the next edge. The bus write in that cycle is dropped.
// STRUCTURE
//  Shared package (mips_dev_pkg):
//   - state encodings IDLE=2'd0, LOAD=2'd1, CNT=2'd2, INT=2'd3
//   - register offset constants CTRL_OFF, PRESET_OFF, COUNT_OFF, ACK_OFF default
//   - byte-merge function merge_be(old, wdata, byteen)
//  No sub-module. The register file, FSM and read mux live in one module of roughly 150-220 lines.
// TESTING
//  1. Reset, then read 0x7f00/04/08/20 -> all 0; irq=0.
//  2. PRESET=5, then CTRL=32'h9 (IM, one-shot, EN).
//     -> COUNT reads 5,4,3,2,1,0; irq rises exactly 8 cycles after the CTRL write edge; CTRL reads 32'h8 afterwards.
//  3. From test 2, store to 0x7f20 with byteen=4'b0001 -> irq=0 the next cycle.
//     A store to 0x7f24 -> no change to pending or irq.
//  4. PRESET=3, CTRL=32'hB (auto-reload). -> pending sets every 5 cycles.
//     An ACK in the same cycle as a set leaves irq=1. COUNT reloads to 3 each period.
//  5. Partial writes: PRESET=32'h1122_3344, then a store of 32'hAA00_0000 with byteen=4'b1000 -> PRESET reads
//     32'hAA22_3344. A write of 0xFFFFFFFF to COUNT is ignored.
//  6. Mid-count: clear EN at COUNT=7 -> COUNT holds 7.
//     Assert reset at COUNT=4 during a CTRL write -> all registers 0 and irq=0 next cycle.

Source files
------------

// File: rtl/mips_dev_pkg.sv
// Shared definitions for the memory-mapped devices on the CPU data bus.
// Holds the timer FSM state encodings, the register window offsets and
// the byte-lane merge helper that every byte-writable register uses.
package mips_dev_pkg;

  // Timer FSM state encodings (2-bit, kept as plain constants for older tools)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Word offsets inside the 64-byte register window
  localparam logic [5:0] CTRL_OFF     = 6'h00;
  localparam logic [5:0] PRESET_OFF   = 6'h04;
  localparam logic [5:0] COUNT_OFF    = 6'h08;
  localparam logic [5:0] ACK_OFF_DFLT = 6'h20;

  // Replace each byte lane of old_val whose enable bit is set with the
  // matching lane of wdata (store data arrives already lane-aligned).
  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  byteen);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_timer_dev.sv
// Countdown timer with interrupt-acknowledge register on the CPU data bus.
// Ports: clk/reset (sync, active-high); addr/byteen/wdata store and load
// interface from the bridge; rdata combinational load data; irq = pending & IM.
module irq_timer_dev
  import mips_dev_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'h0000_7f00,
  parameter logic [5:0]  ACK_OFF = ACK_OFF_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // CTRL layout: [3] IM, [2:1] MODE, [0] EN
  logic [3:0]  ctrl_q,    ctrl_d;
  logic [31:0] preset_q,  preset_d;
  logic [31:0] count_q,   count_d;
  logic        pending_q, pending_d;
  logic [1:0]  state_q,   state_d;

  logic        sel;
  logic        wr;
  logic [5:0]  off;
  logic        ctrl_en;
  logic        ctrl_im;
  logic [1:0]  ctrl_mode;
  logic        unused_addr_lsb;

  assign sel       = (addr[31:6] == BASE[31:6]);
  assign wr        = sel && (byteen != 4'b0000);
  assign off       = {addr[5:2], 2'b00};
  assign ctrl_en   = ctrl_q[0];
  assign ctrl_mode = ctrl_q[2:1];
  assign ctrl_im   = ctrl_q[3];
  // Byte-offset bits are not decoded; loads and stores are word-addressed.
  assign unused_addr_lsb = ^addr[1:0];

  always_comb begin
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    state_d   = state_q;

    // FSM first, from pre-write register values; the bus write below is
    // applied afterwards so it overrides the FSM where both touch a field.
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET of 0 lands here on the first CNT cycle, same as 1
          count_d = 32'd0;
          state_d = ST_INT;
        end
      end
      default: begin  // ST_INT
        pending_d = 1'b1;
        if (ctrl_mode == 2'b01) begin
          state_d = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end
    endcase

    if (wr) begin
      if (off == CTRL_OFF) begin
        // Only the low byte lane carries implemented CTRL bits
        if (byteen[0]) ctrl_d = wdata[3:0];
      end else if (off == PRESET_OFF) begin
        preset_d = merge_be(preset_q, wdata, byteen);
      end else if (off == ACK_OFF) begin
        // A pending set in INT this cycle takes priority over the ack
        if (state_q != ST_INT) pending_d = 1'b0;
      end
      // COUNT and unmapped offsets ignore stores
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      if (off == CTRL_OFF)        rdata = {28'd0, ctrl_q};
      else if (off == PRESET_OFF) rdata = preset_q;
      else if (off == COUNT_OFF)  rdata = count_q;
    end
  end

  assign irq = pending_q & ctrl_im;

endmodule

// File: tb/tb_irq_timer_dev.sv
module tb_irq_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [3:0]  byteen = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  irq_timer_dev dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  localparam logic [31:0] A_CTRL   = 32'h7f00;
  localparam logic [31:0] A_PRESET = 32'h7f04;
  localparam logic [31:0] A_COUNT  = 32'h7f08;
  localparam logic [31:0] A_ACK    = 32'h7f20;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model. The timer is tracked as "cycles since EN was seen":
  // phase 1 is the load cycle, phases 2..max(N,1)+1 are counting cycles with
  // COUNT = N-(phase-2) floored at 0, and phase max(N,1)+2 raises the interrupt.
  bit        m_en, m_im, m_pend, m_act;
  bit [1:0]  m_mode;
  bit [31:0] m_preset, m_count, m_n;
  longint    m_k;

  task automatic model_clear();
    m_en = 0; m_im = 0; m_pend = 0; m_act = 0; m_mode = 0;
    m_preset = 0; m_count = 0; m_n = 0; m_k = 0;
  endtask

  function automatic longint m_last();
    return ((m_n == 0) ? 64'd1 : longint'(m_n)) + 2;
  endfunction

  function automatic bit m_in_int();
    return m_act && (m_k >= 2) && (m_k == m_last());
  endfunction

  function automatic bit [31:0] mread(input bit [31:0] a);
    if ((a & ~32'h3f) != 32'h7f00) return 32'd0;
    case (a[5:0] & 6'h3c)
      6'h00:   return {28'd0, m_im, m_mode, m_en};
      6'h04:   return m_preset;
      6'h08:   return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit [31:0] a, input bit [3:0] be, input bit [31:0] d, input bit r);
    bit set_now;
    set_now = 0;
    if (r) begin
      model_clear();
      return;
    end
    if (!m_act) begin
      if (m_en) begin m_act = 1; m_k = 1; end
    end else if (m_k == 1) begin
      m_count = m_preset; m_n = m_preset; m_k = 2;
    end else if (m_k < m_last()) begin
      if (!m_en) m_act = 0;
      else begin
        m_count = (longint'(m_n) > m_k - 1) ? m_n - 32'(m_k - 1) : 32'd0;
        m_k++;
      end
    end else begin
      set_now = 1; m_pend = 1;
      if (m_mode == 2'b01) m_k = 1;
      else begin m_en = 0; m_act = 0; end
    end
    if ((a & ~32'h3f) == 32'h7f00 && be != 0) begin
      case (a[5:0] & 6'h3c)
        6'h00: if (be[0]) {m_im, m_mode, m_en} = d[3:0];
        6'h04: for (int i = 0; i < 4; i++) if (be[i]) m_preset[i*8 +: 8] = d[i*8 +: 8];
        6'h20: if (!set_now) m_pend = 0;
        default: ;
      endcase
    end
  endtask

  // One bus cycle: check the load data and irq against the model.
  task automatic do_cyc(input bit [31:0] a, input bit [3:0] be, input bit [31:0] d,
                        input bit r, output logic [31:0] rd);
    addr = a; byteen = be; wdata = d; reset = r;
    #1;
    rd = rdata;
    chk("rdata", rdata, mread(a));
    model_step(a, be, d, r);
    @(posedge clk);
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_pend & m_im});
  endtask

  logic [31:0] rd;
  int          rise_at, hi_cnt;
  bit          pre_int, found;

  initial begin
    // Hard reset before the model takes over (DUT regs are X until then)
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // 1: reset values
    do_cyc(A_CTRL, 0, 0, 0, rd);   chk("rst_ctrl", rd, 32'd0);
    do_cyc(A_PRESET, 0, 0, 0, rd); chk("rst_preset", rd, 32'd0);
    do_cyc(A_COUNT, 0, 0, 0, rd);  chk("rst_count", rd, 32'd0);
    do_cyc(A_ACK, 0, 0, 0, rd);    chk("rst_ack", rd, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // 2: one-shot of 5
    do_cyc(A_PRESET, 4'hF, 32'd5, 0, rd);
    do_cyc(A_CTRL, 4'hF, 32'h9, 0, rd);
    rise_at = -1;
    for (int i = 1; i <= 10; i++) begin
      do_cyc(A_COUNT, 0, 0, 0, rd);
      if (i >= 3 && i <= 8) chk("cnt_seq", rd, 32'(8 - i));
      if (irq && rise_at < 0) rise_at = i;
    end
    chk("irq_rise", 32'(rise_at), 32'd8);
    do_cyc(A_CTRL, 0, 0, 0, rd);   chk("ctrl_after", rd, 32'h8);

    // 3: store to a neighbour does nothing, ack clears
    do_cyc(32'h7f24, 4'hF, 32'hFFFF_FFFF, 0, rd);
    chk("ack_neighbour", {31'd0, irq}, 32'd1);
    do_cyc(A_ACK, 4'b0001, 32'd1, 0, rd);
    chk("ack_clear", {31'd0, irq}, 32'd0);

    // 4: auto-reload of 3, acking every cycle
    do_cyc(A_PRESET, 4'hF, 32'd3, 0, rd);
    do_cyc(A_CTRL, 4'hF, 32'hB, 0, rd);
    hi_cnt = 0;
    for (int i = 1; i <= 15; i++) begin
      pre_int = m_in_int();
      do_cyc(A_ACK, 4'hF, 0, 0, rd);
      if (pre_int) chk("ack_vs_set", {31'd0, irq}, 32'd1);
      if (irq) hi_cnt++;
    end
    chk("reload_sets", 32'(hi_cnt), 32'd2);
    for (int i = 0; i < 6; i++) do_cyc(A_COUNT, 0, 0, 0, rd);

    // 5: partial writes, COUNT is read-only
    do_cyc(A_CTRL, 4'hF, 32'h0, 0, rd);
    do_cyc(A_PRESET, 4'hF, 32'h1122_3344, 0, rd);
    do_cyc(A_PRESET, 4'b1000, 32'hAA00_0000, 0, rd);
    do_cyc(A_PRESET, 0, 0, 0, rd); chk("preset_byte", rd, 32'hAA22_3344);
    do_cyc(A_COUNT, 4'hF, 32'hFFFF_FFFF, 0, rd);
    do_cyc(A_COUNT, 0, 0, 0, rd);

    // 6: freeze mid-count, then reset during a CTRL write
    do_cyc(A_PRESET, 4'hF, 32'd10, 0, rd);
    do_cyc(A_CTRL, 4'hF, 32'h1, 0, rd);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_act && m_k >= 2 && m_count == 7) found = 1;
      else do_cyc(A_COUNT, 0, 0, 0, rd);
    end
    chk("wait_cnt7", {31'd0, found}, 32'd1);
    do_cyc(A_CTRL, 4'b0001, 32'h0, 0, rd);
    for (int i = 0; i < 4; i++) do_cyc(A_COUNT, 0, 0, 0, rd);
    do_cyc(A_CTRL, 4'b0001, 32'h9, 0, rd);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_act && m_k >= 2 && m_count == 4) found = 1;
      else do_cyc(A_COUNT, 0, 0, 0, rd);
    end
    chk("wait_cnt4", {31'd0, found}, 32'd1);
    do_cyc(A_CTRL, 4'hF, 32'hF, 1, rd);
    chk("rst_mid_irq", {31'd0, irq}, 32'd0);
    do_cyc(A_CTRL, 0, 0, 0, rd);   chk("rst_mid_ctrl", rd, 32'd0);
    do_cyc(A_PRESET, 0, 0, 0, rd); chk("rst_mid_preset", rd, 32'd0);
    do_cyc(A_COUNT, 0, 0, 0, rd);  chk("rst_mid_count", rd, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int op;
      bit [31:0] a;
      op = $urandom_range(0, 19);
      a  = 32'h7f00 | ($urandom_range(0, 15) << 2);
      case (op)
        0, 1, 2: do_cyc(A_CTRL, 4'($urandom_range(0, 15)), $urandom, 0, rd);
        3, 4:    do_cyc(A_PRESET, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF,
                        32'($urandom_range(0, 7)), 0, rd);
        5, 6:    do_cyc(A_ACK, 4'($urandom_range(0, 15)), $urandom, 0, rd);
        7:       do_cyc(a, 4'($urandom_range(1, 15)), $urandom, 0, rd);
        8:       do_cyc(32'h7f40 | a[5:0], 4'hF, $urandom, 0, rd);
        9:       do_cyc(a, 4'hF, $urandom, ($urandom_range(0, 29) == 0), rd);
        default: do_cyc(($urandom_range(0, 7) == 0) ? (32'h8f00 | a[5:0]) : a, 4'd0, $urandom, 0, rd);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
